// File: rtl/wb_initiator_bridge.sv
// wb_initiator_bridge: single-transaction valid/ready to Wishbone classic initiator
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module wb_initiator_bridge #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic [1:0]        rsp_status,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [SEL_W-1:0]  wb_sel,
  output logic [DATA_W-1:0] wb_dat_w,
  input  logic [DATA_W-1:0] wb_dat_r,
  input  logic              wb_ack,
  input  logic              wb_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_nx;
  logic hit, term;
`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  // Counter is zero whenever not waiting in BUS, so it starts cleared on entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else cnt <= (state == BUS && !(wb_ack || wb_err)) ? cnt + 1'b1 : '0;
  assign hit = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign hit = TIMEOUT_CYCLES < 0;
`endif
  assign term = wb_ack || wb_err || hit;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (req_valid ? BUS : IDLE)
             : state == BUS  ? (term ? RESP : BUS)
             : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_sel     <= '0;
      wb_dat_w   <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= 2'b00;
    end else if (state == IDLE && req_valid) begin
      wb_cyc   <= 1'b1;
      wb_stb   <= 1'b1;
      wb_we    <= req_we;
      wb_adr   <= req_adr;
      wb_sel   <= req_sel;
      wb_dat_w <= req_dat;
    end else if (state == BUS && term) begin
      // Error outranks ack, and either outranks timeout expiry.
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      rsp_valid  <= 1'b1;
      rsp_status <= wb_err ? 2'b01 : wb_ack ? 2'b00 : 2'b10;
      rsp_dat    <= (!wb_err && wb_ack && !wb_we) ? wb_dat_r : '0;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
endmodule
